// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV64 memory-access stage: req/ack data port, byte lanes, load extension
// Ports:
//   clk, rst (async, active-low)
//   EX/MEM side : valid_in, mem_read, mem_write, funct3, alu_addr, store_data,
//                 wb_ctrl_in, rd_idx_in, stall (freezes upstream while a request is open)
//   data memory : mem_req, mem_we, mem_addr, mem_wdata, mem_be (registered), mem_rdata, mem_ack
//   MEM/WB side : rd_data_out, addr_out, control_out, rd_idx_out, valid_out, mem_fault
module mem_access_stage #(
  parameter int DATA_LEN         = 64,
  parameter int CONTROL_LINE     = 2,
  parameter int INSTRUCTION_PART = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [2:0]                  funct3,
  input  logic [DATA_LEN-1:0]         alu_addr,
  input  logic [DATA_LEN-1:0]         store_data,
  input  logic [CONTROL_LINE-1:0]     wb_ctrl_in,
  input  logic [INSTRUCTION_PART-1:0] rd_idx_in,
  output logic                        stall,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [DATA_LEN-1:0]         mem_addr,
  output logic [DATA_LEN-1:0]         mem_wdata,
  output logic [7:0]                  mem_be,
  input  logic [DATA_LEN-1:0]         mem_rdata,
  input  logic                        mem_ack,
  output logic [DATA_LEN-1:0]         rd_data_out,
  output logic [DATA_LEN-1:0]         addr_out,
  output logic [CONTROL_LINE-1:0]     control_out,
  output logic [INSTRUCTION_PART-1:0] rd_idx_out,
  output logic                        valid_out,
  output logic                        mem_fault
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                        r_state;
  state_t                        w_next_state;

  // Instruction captured on acceptance, replayed to MEM/WB when the ack arrives.
  logic [2:0]                    r_funct3;
  logic                          r_is_load;
  logic [DATA_LEN-1:0]           r_addr;
  logic [CONTROL_LINE-1:0]       r_ctrl;
  logic [INSTRUCTION_PART-1:0]   r_idx;

  logic                          w_is_mem;
  logic                          w_illegal;
  logic                          w_misaligned;
  logic                          w_reject;
  logic                          w_accept_mem;
  logic [7:0]                    w_size_mask;
  logic [DATA_LEN-1:0]           w_lane;
  logic [DATA_LEN-1:0]           w_load;

  // Decode of the incoming instruction: legality, alignment and lane mask.
  always_comb begin
    w_is_mem  = mem_read | mem_write;
    w_illegal = (mem_read & mem_write) |
                (mem_read & (funct3 == 3'b111)) |
                (mem_write & funct3[2]);
    case (funct3[1:0])
      2'b00:   begin w_misaligned = 1'b0;            w_size_mask = 8'h01; end
      2'b01:   begin w_misaligned = alu_addr[0];     w_size_mask = 8'h03; end
      2'b10:   begin w_misaligned = |alu_addr[1:0];  w_size_mask = 8'h0F; end
      default: begin w_misaligned = |alu_addr[2:0];  w_size_mask = 8'hFF; end
    endcase
    w_reject     = w_illegal | w_misaligned;
    w_accept_mem = valid_in & w_is_mem & ~w_reject;
  end

  // Load extraction: bring the addressed lane down to bit 0, then extend by size.
  always_comb begin
    w_lane = mem_rdata >> {r_addr[2:0], 3'b000};
    case (r_funct3[1:0])
      2'b00:   w_load = {{(DATA_LEN-8){~r_funct3[2] & w_lane[7]}},   w_lane[7:0]};
      2'b01:   w_load = {{(DATA_LEN-16){~r_funct3[2] & w_lane[15]}}, w_lane[15:0]};
      2'b10:   w_load = {{(DATA_LEN-32){~r_funct3[2] & w_lane[31]}}, w_lane[31:0]};
      default: w_load = w_lane;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept_mem) w_next_state = S_WAIT;
      S_WAIT:  if (mem_ack)      w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  // Output logic: upstream is frozen for as long as a request is open.
  always_comb begin
    stall = (r_state == S_WAIT);
  end

  // Registered memory port, capture registers and MEM/WB results.
  // valid_out, mem_fault and control_out default to zero so every cycle that
  // does not retire an instruction is a clean bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      rd_data_out <= '0;
      addr_out    <= '0;
      control_out <= '0;
      rd_idx_out  <= '0;
      valid_out   <= 1'b0;
      mem_fault   <= 1'b0;
      r_funct3    <= '0;
      r_is_load   <= 1'b0;
      r_addr      <= '0;
      r_ctrl      <= '0;
      r_idx       <= '0;
    end else begin
      valid_out   <= 1'b0;
      mem_fault   <= 1'b0;
      control_out <= '0;
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            if (!w_is_mem) begin
              addr_out    <= alu_addr;
              control_out <= wb_ctrl_in;
              rd_idx_out  <= rd_idx_in;
              rd_data_out <= '0;
              valid_out   <= 1'b1;
            end else if (w_reject) begin
              mem_fault   <= 1'b1;
            end else begin
              r_funct3    <= funct3;
              r_is_load   <= mem_read;
              r_addr      <= alu_addr;
              r_ctrl      <= wb_ctrl_in;
              r_idx       <= rd_idx_in;
              mem_req     <= 1'b1;
              mem_we      <= mem_write;
              mem_addr    <= {alu_addr[DATA_LEN-1:3], 3'b000};
              mem_wdata   <= store_data << {alu_addr[2:0], 3'b000};
              mem_be      <= w_size_mask << alu_addr[2:0];
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            valid_out   <= 1'b1;
            control_out <= r_ctrl;
            rd_idx_out  <= r_idx;
            addr_out    <= r_addr;
            rd_data_out <= r_is_load ? w_load : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] alu_addr = '0, store_data = '0, mem_rdata = '0;
  logic [1:0]  wb_ctrl_in = '0;
  logic [4:0]  rd_idx_in = '0;
  logic        mem_ack = 1'b0;
  logic        stall, mem_req, mem_we, valid_out, mem_fault;
  logic [63:0] mem_addr, mem_wdata, rd_data_out, addr_out;
  logic [7:0]  mem_be;
  logic [1:0]  control_out;
  logic [4:0]  rd_idx_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_LEN(64), .CONTROL_LINE(2), .INSTRUCTION_PART(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .alu_addr(alu_addr), .store_data(store_data), .wb_ctrl_in(wb_ctrl_in),
    .rd_idx_in(rd_idx_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rd_data_out(rd_data_out), .addr_out(addr_out),
    .control_out(control_out), .rd_idx_out(rd_idx_out), .valid_out(valid_out),
    .mem_fault(mem_fault)
  );

  typedef struct {
    logic        req1, we1, stall1, held, leak;
    logic [63:0] addr1, wdata1;
    logic [7:0]  be1;
    int          stall_cnt;
    logic        vout, fault;
    logic [63:0] rdo, ao;
    logic [1:0]  co;
    logic [4:0]  idx;
    logic        vout2, fault2;
    logic [1:0]  co2;
  } obs_t;

  // ---------------- reference model (byte-level view of the rules) ----------------
  function automatic logic [63:0] ref_load(logic [63:0] rd, logic [63:0] a, logic [2:0] f3);
    int nbytes = 1 << f3[1:0];
    int off    = int'(a[2:0]);
    logic [63:0] v = '0;
    for (int b = 0; b < nbytes; b++) v[8*b +: 8] = rd[8*(off+b) +: 8];
    if (!f3[2] && v[8*nbytes-1])
      for (int b = nbytes; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] ref_be(logic [63:0] a, logic [2:0] f3);
    logic [7:0] be = '0;
    for (int b = 0; b < (1 << f3[1:0]); b++) be[int'(a[2:0]) + b] = 1'b1;
    return be;
  endfunction

  function automatic logic ref_fault(logic rd, logic wr, logic [2:0] f3, logic [63:0] a);
    int nbytes = 1 << f3[1:0];
    if (!rd && !wr)            return 1'b0;
    if (rd && wr)              return 1'b1;
    if (rd && f3 == 3'b111)    return 1'b1;
    if (wr && f3[2])           return 1'b1;
    return (int'(a[2:0]) % nbytes) != 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction, plays a memory that acks after `delay` extra request
  // cycles, and records what the DUT showed along the way.
  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] sd, input logic [1:0] ctrl,
                          input logic [4:0] idx, input logic [63:0] rdata, input int delay,
                          output obs_t o);
    valid_in = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    alu_addr = a; store_data = sd; wb_ctrl_in = ctrl; rd_idx_in = idx;
    cyc();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_addr = {$urandom, $urandom}; store_data = {$urandom, $urandom};
    o.req1 = mem_req; o.we1 = mem_we; o.addr1 = mem_addr; o.wdata1 = mem_wdata;
    o.be1 = mem_be; o.stall1 = stall; o.stall_cnt = 0; o.held = 1'b1; o.leak = 1'b0;
    if (mem_req) begin
      for (int i = 0; i <= delay; i++) begin
        if (stall) o.stall_cnt++;
        if (mem_req !== 1'b1 || mem_we !== o.we1 || mem_addr !== o.addr1 ||
            mem_wdata !== o.wdata1 || mem_be !== o.be1) o.held = 1'b0;
        if (valid_out || mem_fault || control_out != 2'b00) o.leak = 1'b1;
        if (i == delay) begin mem_ack = 1'b1; mem_rdata = rdata; end
        cyc();
      end
      mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
    end
    o.vout = valid_out; o.fault = mem_fault; o.rdo = rd_data_out; o.ao = addr_out;
    o.co = control_out; o.idx = rd_idx_out;
    cyc();
    o.vout2 = valid_out; o.fault2 = mem_fault; o.co2 = control_out;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) cyc();
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    n_cmp++; if ({mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin n_fail++;
      $display("FAIL reset_memport got we=%b addr=%h wdata=%h be=%h exp all 0", mem_we, mem_addr, mem_wdata, mem_be); end
    n_cmp++; if ({rd_data_out, addr_out, control_out, rd_idx_out} !== '0) begin n_fail++;
      $display("FAIL reset_wb got rd=%h addr=%h ctrl=%h idx=%h exp all 0", rd_data_out, addr_out, control_out, rd_idx_out); end
    n_cmp++; if ({valid_out, mem_fault} !== 2'b00) begin n_fail++;
      $display("FAIL reset_flags got valid=%b fault=%b exp 0 0", valid_out, mem_fault); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_alu_op();
    obs_t o;
    drive_op(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 2'b11, 5'd5, 64'h0, 0, o);
    n_cmp++; if ({o.vout, o.ao, o.co, o.idx, o.rdo} !== {1'b1, 64'h1234, 2'b11, 5'd5, 64'h0}) begin n_fail++;
      $display("FAIL alu_retire got v=%b addr=%h ctrl=%h idx=%0d rd=%h exp 1 1234 3 5 0", o.vout, o.ao, o.co, o.idx, o.rdo); end
    n_cmp++; if ({o.stall1, o.req1, o.fault} !== 3'b000) begin n_fail++;
      $display("FAIL alu_nostall got stall=%b req=%b fault=%b exp 0 0 0", o.stall1, o.req1, o.fault); end
    n_cmp++; if ({o.vout2, o.co2} !== 3'b000) begin n_fail++;
      $display("FAIL alu_one_cycle got valid=%b ctrl=%h exp 0 0", o.vout2, o.co2); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    logic [63:0] rdata = 64'h1122_3344_80AA_BBCC;
    drive_op(1'b1, 1'b0, 3'b000, 64'h4000_0003, 64'h0, 2'b01, 5'd3, rdata, 3, o);
    n_cmp++; if ({o.req1, o.we1, o.addr1} !== {1'b1, 1'b0, 64'h4000_0000}) begin n_fail++;
      $display("FAIL lb_req got req=%b we=%b addr=%h exp 1 0 4000_0000", o.req1, o.we1, o.addr1); end
    n_cmp++; if (o.stall_cnt != 4) begin n_fail++; $display("FAIL lb_stall_cycles got=%0d exp=4", o.stall_cnt); end
    n_cmp++; if (o.rdo !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++;
      $display("FAIL lb_value got=%h exp=ffffffffffffff80", o.rdo); end
    n_cmp++; if ({o.vout, o.idx, o.ao, o.held, o.leak} !== {1'b1, 5'd3, 64'h4000_0003, 1'b1, 1'b0}) begin n_fail++;
      $display("FAIL lb_retire got v=%b idx=%0d addr=%h held=%b leak=%b", o.vout, o.idx, o.ao, o.held, o.leak); end
    drive_op(1'b1, 1'b0, 3'b100, 64'h4000_0003, 64'h0, 2'b01, 5'd3, rdata, 3, o);
    n_cmp++; if (o.rdo !== 64'h80) begin n_fail++; $display("FAIL lbu_value got=%h exp=80", o.rdo); end
  endtask

  task automatic test_store_half();
    obs_t o;
    drive_op(1'b0, 1'b1, 3'b001, 64'h6, 64'hBEEF, 2'b10, 5'd0, {$urandom, $urandom}, 1, o);
    n_cmp++; if ({o.req1, o.we1, o.be1} !== {1'b1, 1'b1, 8'hC0}) begin n_fail++;
      $display("FAIL sh_port got req=%b we=%b be=%h exp 1 1 c0", o.req1, o.we1, o.be1); end
    n_cmp++; if (o.wdata1[63:48] !== 16'hBEEF) begin n_fail++;
      $display("FAIL sh_wdata got=%h exp=beef", o.wdata1[63:48]); end
    n_cmp++; if ({o.vout, o.rdo, o.co} !== {1'b1, 64'h0, 2'b10}) begin n_fail++;
      $display("FAIL sh_retire got v=%b rd=%h ctrl=%h exp 1 0 2", o.vout, o.rdo, o.co); end
  endtask

  task automatic test_faults();
    obs_t o;
    drive_op(1'b1, 1'b0, 3'b010, 64'h2, 64'h0, 2'b11, 5'd4, 64'h0, 0, o);
    n_cmp++; if ({o.req1, o.fault, o.vout, o.co} !== {1'b0, 1'b1, 1'b0, 2'b00}) begin n_fail++;
      $display("FAIL lw_misaligned got req=%b fault=%b valid=%b ctrl=%h exp 0 1 0 0", o.req1, o.fault, o.vout, o.co); end
    n_cmp++; if (o.fault2 !== 1'b0) begin n_fail++; $display("FAIL lw_fault_one_cycle got=%b exp=0", o.fault2); end
    drive_op(1'b1, 1'b0, 3'b111, 64'h8, 64'h0, 2'b11, 5'd4, 64'h0, 0, o);
    n_cmp++; if ({o.req1, o.fault, o.vout, o.co, o.fault2} !== {1'b0, 1'b1, 1'b0, 2'b00, 1'b0}) begin n_fail++;
      $display("FAIL ld_f3_111 got req=%b fault=%b valid=%b ctrl=%h next_fault=%b", o.req1, o.fault, o.vout, o.co, o.fault2); end
  endtask

  // Upstream model: an instruction leaves EX/MEM only on an edge where stall was low.
  task automatic test_back_to_back();
    logic [4:0]  ret[$];
    int          ret_cyc[$];
    int          issued = 0;
    int          req_cycles = 0;
    logic        s;
    for (int c = 0; c < 10; c++) begin
      if (issued == 0) begin
        valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011;
        alu_addr = 64'h2000_0008; wb_ctrl_in = 2'b10; rd_idx_in = 5'd7;
      end else if (issued == 1) begin
        valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        alu_addr = 64'h55; wb_ctrl_in = 2'b01; rd_idx_in = 5'd9;
      end else valid_in = 1'b0;
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 3) begin mem_ack = 1'b1; mem_rdata = 64'hCAFE_0000_1234_5678; end
      end
      s = stall;
      cyc();
      mem_ack = 1'b0;
      if (valid_in && !s) issued++;
      if (valid_out) begin ret.push_back(rd_idx_out); ret_cyc.push_back(c); end
      if (valid_out && rd_idx_out == 5'd7) begin
        n_cmp++; if (rd_data_out !== 64'hCAFE_0000_1234_5678) begin n_fail++;
          $display("FAIL b2b_ld_value got=%h exp=cafe000012345678", rd_data_out); end
      end
      if (valid_out && rd_idx_out == 5'd9) begin
        n_cmp++; if ({addr_out, control_out, rd_data_out} !== {64'h55, 2'b01, 64'h0}) begin n_fail++;
          $display("FAIL b2b_add_fields got addr=%h ctrl=%h rd=%h exp 55 1 0", addr_out, control_out, rd_data_out); end
      end
    end
    valid_in = 1'b0;
    n_cmp++; if (ret.size() != 2) begin n_fail++; $display("FAIL b2b_retire_count got=%0d exp=2", ret.size()); end
    else begin
      n_cmp++; if (ret[0] !== 5'd7 || ret[1] !== 5'd9 || ret_cyc[1] != ret_cyc[0] + 1) begin n_fail++;
        $display("FAIL b2b_order got idx=%0d,%0d at %0d,%0d exp 7,9 consecutive", ret[0], ret[1], ret_cyc[0], ret_cyc[1]); end
    end
  endtask

  task automatic test_reset_in_wait();
    obs_t o;
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b011;
    alu_addr = 64'h3000; wb_ctrl_in = 2'b11; rd_idx_in = 5'd12;
    cyc();
    valid_in = 1'b0; mem_read = 1'b0;
    cyc();
    n_cmp++; if ({mem_req, stall} !== 2'b11) begin n_fail++;
      $display("FAIL rstwait_pending got req=%b stall=%b exp 1 1", mem_req, stall); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({mem_req, stall, mem_we, mem_addr, mem_be, valid_out, control_out, addr_out} !== '0) begin n_fail++;
      $display("FAIL rstwait_immediate got req=%b stall=%b addr=%h valid=%b exp all 0", mem_req, stall, mem_addr, valid_out); end
    cyc();
    rst = 1'b1;
    cyc();
    mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    mem_ack = 1'b0;
    n_cmp++; if ({valid_out, mem_req, stall, mem_fault} !== 4'b0000) begin n_fail++;
      $display("FAIL rstwait_late_ack got valid=%b req=%b stall=%b fault=%b exp 0 0 0 0", valid_out, mem_req, stall, mem_fault); end
    drive_op(1'b1, 1'b0, 3'b110, 64'h3004, 64'h0, 2'b01, 5'd13, 64'h8000_0001_0000_0000, 0, o);
    n_cmp++; if ({o.vout, o.idx, o.rdo, o.stall_cnt} !== {1'b1, 5'd13, 64'h8000_0001, 32'd1}) begin n_fail++;
      $display("FAIL rstwait_next_op got v=%b idx=%0d rd=%h stalls=%0d exp 1 13 80000001 1", o.vout, o.idx, o.rdo, o.stall_cnt); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 60; n++) begin
      int          kind  = $urandom_range(0, 9);
      logic        rd    = (kind >= 2 && kind <= 5) || kind == 9;
      logic        wr    = kind >= 6;
      logic [2:0]  f3    = 3'($urandom_range(0, 7));
      logic [63:0] a     = {$urandom, $urandom};
      logic [63:0] sd    = {$urandom, $urandom};
      logic [63:0] rdata = {$urandom, $urandom};
      logic [1:0]  ctrl  = 2'($urandom_range(0, 3));
      logic [4:0]  idx   = 5'($urandom_range(0, 31));
      int          delay = $urandom_range(0, 3);
      logic        flt;
      if ($urandom_range(0, 3) != 0) a = a & ~(64'((1 << f3[1:0]) - 1));
      flt = ref_fault(rd, wr, f3, a);
      drive_op(rd, wr, f3, a, sd, ctrl, idx, rdata, delay, o);
      n_cmp++; if ({o.vout2, o.fault2, o.co2} !== 4'b0000) begin n_fail++;
        $display("FAIL rnd_bubble_after[%0d] got v=%b f=%b ctrl=%h exp 0 0 0", n, o.vout2, o.fault2, o.co2); end
      if (!rd && !wr) begin
        n_cmp++; if ({o.vout, o.fault, o.ao, o.co, o.idx, o.rdo, o.stall1} !== {2'b10, a, ctrl, idx, 64'h0, 1'b0}) begin n_fail++;
          $display("FAIL rnd_alu[%0d] got v=%b addr=%h ctrl=%h idx=%0d exp addr=%h ctrl=%h idx=%0d", n, o.vout, o.ao, o.co, o.idx, a, ctrl, idx); end
      end else if (flt) begin
        n_cmp++; if ({o.req1, o.fault, o.vout, o.co} !== {1'b0, 1'b1, 1'b0, 2'b00}) begin n_fail++;
          $display("FAIL rnd_fault[%0d] got req=%b fault=%b valid=%b ctrl=%h exp 0 1 0 0 (rd=%b wr=%b f3=%0d a=%h)", n, o.req1, o.fault, o.vout, o.co, rd, wr, f3, a); end
      end else begin
        n_cmp++; if ({o.req1, o.we1, o.addr1, o.held, o.leak, o.stall_cnt} !== {1'b1, wr, a & ~64'h7, 2'b10, 32'(delay + 1)}) begin n_fail++;
          $display("FAIL rnd_request[%0d] got req=%b we=%b addr=%h held=%b leak=%b stalls=%0d exp we=%b stalls=%0d", n, o.req1, o.we1, o.addr1, o.held, o.leak, o.stall_cnt, wr, delay + 1); end
        if (wr) begin
          n_cmp++; if ({o.be1, o.wdata1} !== {ref_be(a, f3), sd << (8 * int'(a[2:0]))}) begin n_fail++;
            $display("FAIL rnd_store_lanes[%0d] got be=%h wdata=%h exp be=%h", n, o.be1, o.wdata1, ref_be(a, f3)); end
        end
        n_cmp++; if ({o.vout, o.fault, o.ao, o.co, o.idx, o.rdo} !== {2'b10, a, ctrl, idx, rd ? ref_load(rdata, a, f3) : 64'h0}) begin n_fail++;
          $display("FAIL rnd_retire[%0d] got v=%b rd=%h addr=%h idx=%0d exp rd=%h (f3=%0d a=%h)", n, o.vout, o.rdo, o.ao, o.idx, rd ? ref_load(rdata, a, f3) : 64'h0, f3, a); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_byte();
    test_store_half();
    test_faults();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
